// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the memory-port arbiter: the CPU datapath width,
//   the arbiter FSM state encoding and the owner (requester) encoding.
//   There are no ports; the package is imported by rr_arb2 and mem_arbiter.
package mem_arbiter_pkg;

  localparam int CPU_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  // The requester that did not take the previous grant.
  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_IFU) ? OWN_LSU : OWN_IFU;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2
//   Combinational 2-way round-robin grant.
//   Ports:
//     ifu_valid  in   IFU is requesting
//     lsu_valid  in   LSU is requesting
//     last_grant in   owner of the most recently completed transaction
//     gnt_valid  out  some requester is granted
//     gnt        out  granted owner (meaningful only when gnt_valid)
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic   ifu_valid,
  input  logic   lsu_valid,
  input  owner_t last_grant,
  output logic   gnt_valid,
  output owner_t gnt
);

  always_comb begin
    gnt_valid = ifu_valid | lsu_valid;
    gnt       = OWN_IFU;
    if (ifu_valid && lsu_valid) begin
      // On a tie the requester that was not served last wins.
      gnt = other_owner(last_grant);
    end else if (lsu_valid) begin
      gnt = OWN_LSU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single memory port between the IFU (read-only fetch) and the
//   LSU (load/store). One transaction is outstanding at a time; the slave
//   response is buffered and returned to the master that issued it. A
//   response-timeout counter completes the transaction with an error if the
//   slave never answers.
//   Ports:
//     clk, rst                      clock, asynchronous active-high reset
//     ifu_req_*/ifu_addr            IFU request channel
//     ifu_resp_*/ifu_rdata          IFU response channel (+ timeout error)
//     lsu_req_*/lsu_addr/wen/wdata/wmask   LSU request channel
//     lsu_resp_*/lsu_rdata          LSU response channel (+ timeout error)
//     mem_req_*/mem_addr/wen/wdata/wmask   request to the memory slave
//     mem_resp_*/mem_rdata          response from the memory slave
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = CPU_WIDTH,
  parameter int DATA_W  = CPU_WIDTH,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_resp_err,

  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_resp_err,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  output logic                mem_resp_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_t state_q, state_n;
  owner_t     last_grant_q;
  owner_t     owner_q;
  owner_t     gnt;
  logic       gnt_valid;

  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  logic accept;
  logic timeout;
  logic owner_resp_ready;

  rr_arb2 u_rr_arb2 (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt        (gnt)
  );

  assign accept           = (state_q == ST_IDLE) && gnt_valid && !rst;
  assign timeout          = (cnt_q == CNT_LAST);
  assign owner_resp_ready = (owner_q == OWN_IFU) ? ifu_resp_ready : lsu_resp_ready;

  // Next-state and handshake outputs. Everything is forced low while rst is
  // high, because IDLE otherwise exposes combinational ready signals.
  always_comb begin
    state_n        = state_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          ifu_req_ready  = gnt_valid && (gnt == OWN_IFU);
          lsu_req_ready  = gnt_valid && (gnt == OWN_LSU);
          // Stray or late slave responses are drained and discarded here.
          mem_resp_ready = 1'b1;
          if (gnt_valid) state_n = ST_REQ;
        end
        ST_REQ: begin
          mem_req_valid = 1'b1;
          if (mem_req_ready) state_n = ST_RESP;
        end
        ST_RESP: begin
          mem_resp_ready = 1'b1;
          if (mem_resp_valid || timeout) state_n = ST_DONE;
        end
        ST_DONE: begin
          ifu_resp_valid = (owner_q == OWN_IFU);
          lsu_resp_valid = (owner_q == OWN_LSU);
          if (owner_resp_ready) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= OWN_LSU;
      owner_q      <= OWN_IFU;
      cnt_q        <= '0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_n;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            owner_q <= gnt;
            if (gnt == OWN_IFU) begin
              // Fetches are always reads with no byte strobes.
              addr_q  <= ifu_addr;
              wen_q   <= 1'b0;
              wdata_q <= '0;
              wmask_q <= '0;
            end else begin
              addr_q  <= lsu_addr;
              wen_q   <= lsu_wen;
              wdata_q <= lsu_wdata;
              wmask_q <= lsu_wmask;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) cnt_q <= '0;
        end
        ST_RESP: begin
          if (mem_resp_valid) begin
            rdata_q <= wen_q ? '0 : mem_rdata;
            err_q   <= 1'b0;
          end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            // Saturating so a maximal TIMEOUT can never wrap the count.
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (owner_resp_ready) last_grant_q <= owner_q;
        end
        default: ;
      endcase
    end
  end

  // Latched request fields are held steady for the slave; buffered response
  // data is steered only to the owning master.
  assign mem_addr     = addr_q;
  assign mem_wen      = wen_q;
  assign mem_wdata    = wdata_q;
  assign mem_wmask    = wmask_q;
  assign ifu_rdata    = (owner_q == OWN_IFU) ? rdata_q : '0;
  assign lsu_rdata    = (owner_q == OWN_LSU) ? rdata_q : '0;
  assign ifu_resp_err = (owner_q == OWN_IFU) && err_q;
  assign lsu_resp_err = (owner_q == OWN_LSU) && err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_rdata;
  logic        ifu_resp_err;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid, lsu_resp_ready;
  logic [31:0] lsu_rdata;
  logic        lsu_resp_err;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h0; ifu_resp_ready = 1'b0;
    lsu_req_valid = 1'b1; lsu_addr = 32'h0; lsu_wen = 1'b0;
    lsu_wdata = 32'h0; lsu_wmask = 4'h0; lsu_resp_ready = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0;
    nxt(); nxt();
    // Outputs are all low under reset even with requests pending.
    chk("rst_ifu_req_ready", ifu_req_ready, 0);
    chk("rst_lsu_req_ready", lsu_req_ready, 0);
    chk("rst_mem_resp_ready", mem_resp_ready, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);

    // ---- IFU only, minimum latency ----
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_resp_valid = 1'b0;
    rst = 1'b0;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    mem_req_ready = 1'b1; ifu_resp_ready = 1'b1;
    settle();
    chk("c0_ifu_req_ready", ifu_req_ready, 1);
    chk("c0_lsu_req_ready", lsu_req_ready, 0);
    chk("c0_mem_req_valid", mem_req_valid, 0);
    nxt();
    ifu_req_valid = 1'b0;
    settle();
    chk("c1_mem_req_valid", mem_req_valid, 1);
    chk("c1_mem_addr", mem_addr, 32'h8000_0000);
    chk("c1_mem_wen", mem_wen, 0);
    nxt();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0010_0073;
    settle();
    chk("c2_mem_resp_ready", mem_resp_ready, 1);
    chk("c2_ifu_resp_valid", ifu_resp_valid, 0);
    nxt();
    mem_resp_valid = 1'b0;
    settle();
    chk("c3_ifu_resp_valid", ifu_resp_valid, 1);
    chk("c3_ifu_rdata", ifu_rdata, 32'h0010_0073);
    chk("c3_ifu_resp_err", ifu_resp_err, 0);
    chk("c3_lsu_resp_valid", lsu_resp_valid, 0);
    nxt();
    ifu_resp_ready = 1'b0;
    settle();
    chk("c4_ifu_resp_valid", ifu_resp_valid, 0);

    // ---- Fresh reset, then a tie: IFU first ----
    rst = 1'b1; settle(); nxt(); rst = 1'b0;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0100; lsu_wen = 1'b1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    mem_req_ready = 1'b0;
    settle();
    chk("tie1_ifu_req_ready", ifu_req_ready, 1);
    chk("tie1_lsu_req_ready", lsu_req_ready, 0);
    nxt();
    ifu_req_valid = 1'b0;
    // Slave stalls five cycles; request must stay stable.
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("stall%0d_mem_req_valid", i), mem_req_valid, 1);
      chk($sformatf("stall%0d_mem_addr", i), mem_addr, 32'h8000_0004);
      chk($sformatf("stall%0d_mem_wen", i), mem_wen, 0);
      chk($sformatf("stall%0d_mem_wmask", i), mem_wmask, 0);
      chk($sformatf("stall%0d_lsu_req_ready", i), lsu_req_ready, 0);
      nxt();
    end
    mem_req_ready = 1'b1;
    settle();
    chk("stall_end_mem_req_valid", mem_req_valid, 1);
    nxt();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_0001;
    settle();
    chk("stall_resp_ready", mem_resp_ready, 1);
    nxt();
    mem_resp_valid = 1'b0;
    // IFU stalls the response three cycles.
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("hold%0d_ifu_resp_valid", i), ifu_resp_valid, 1);
      chk($sformatf("hold%0d_ifu_rdata", i), ifu_rdata, 32'hCAFE_0001);
      chk($sformatf("hold%0d_lsu_req_ready", i), lsu_req_ready, 0);
      chk($sformatf("hold%0d_mem_req_valid", i), mem_req_valid, 0);
      nxt();
    end
    ifu_resp_ready = 1'b1;
    settle();
    chk("hold_release_ifu_resp_valid", ifu_resp_valid, 1);
    nxt();
    ifu_resp_ready = 1'b0;
    // Second tie: LSU wins, store.
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0008;
    settle();
    chk("tie2_lsu_req_ready", lsu_req_ready, 1);
    chk("tie2_ifu_req_ready", ifu_req_ready, 0);
    nxt();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    settle();
    chk("st_mem_wen", mem_wen, 1);
    chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("st_mem_wmask", mem_wmask, 4'hF);
    chk("st_mem_addr", mem_addr, 32'h8000_0100);
    mem_req_ready = 1'b1;
    nxt();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    nxt();
    mem_resp_valid = 1'b0;
    settle();
    chk("st_lsu_resp_valid", lsu_resp_valid, 1);
    chk("st_lsu_rdata", lsu_rdata, 0);
    chk("st_lsu_resp_err", lsu_resp_err, 0);
    chk("st_ifu_resp_valid", ifu_resp_valid, 0);
    lsu_resp_ready = 1'b1;
    nxt();
    lsu_resp_ready = 1'b0;

    // ---- Timeout: LSU load, slave never answers (TIMEOUT = 4) ----
    lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_0200;
    lsu_wmask = 4'h0; mem_req_ready = 1'b1;
    settle();
    chk("to_lsu_req_ready", lsu_req_ready, 1);
    nxt();
    lsu_req_valid = 1'b0;
    nxt();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("to_wait%0d_lsu_resp_valid", i), lsu_resp_valid, 0);
      nxt();
    end
    chk("to_lsu_resp_valid", lsu_resp_valid, 1);
    chk("to_lsu_resp_err", lsu_resp_err, 1);
    chk("to_lsu_rdata", lsu_rdata, 0);
    lsu_resp_ready = 1'b1;
    nxt();
    lsu_resp_ready = 1'b0;

    // ---- Late response in IDLE is dropped ----
    mem_resp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    settle();
    chk("late_mem_resp_ready", mem_resp_ready, 1);
    chk("late_ifu_resp_valid", ifu_resp_valid, 0);
    nxt();
    mem_resp_valid = 1'b0;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0008; mem_req_ready = 1'b1;
    nxt();
    ifu_req_valid = 1'b0;
    nxt();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0013;
    nxt();
    mem_resp_valid = 1'b0;
    settle();
    chk("after_late_ifu_resp_valid", ifu_resp_valid, 1);
    chk("after_late_ifu_rdata", ifu_rdata, 32'h0000_0013);
    chk("after_late_ifu_resp_err", ifu_resp_err, 0);
    ifu_resp_ready = 1'b1;
    nxt();
    ifu_resp_ready = 1'b0;

    // ---- Reset during RESP (last grant is IFU here) ----
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_000C; mem_req_ready = 1'b1;
    nxt();
    ifu_req_valid = 1'b0;
    nxt();
    mem_req_ready = 1'b0;
    settle();
    chk("mid_mem_resp_ready", mem_resp_ready, 1);
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_wen = 1'b0; ifu_resp_ready = 1'b1;
    rst = 1'b1;
    settle();
    chk("mid_rst_mem_resp_ready", mem_resp_ready, 0);
    chk("mid_rst_ifu_req_ready", ifu_req_ready, 0);
    chk("mid_rst_lsu_req_ready", lsu_req_ready, 0);
    chk("mid_rst_mem_req_valid", mem_req_valid, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_ifu_resp_valid", ifu_resp_valid, 0);
    nxt();
    rst = 1'b0;
    settle();
    chk("post_rst_ifu_req_ready", ifu_req_ready, 1);
    chk("post_rst_lsu_req_ready", lsu_req_ready, 0);
    chk("post_rst_ifu_resp_valid", ifu_resp_valid, 0);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
    nxt();
    mem_resp_valid = 1'b0;
    settle();
    chk("post_rst_idle_mem_req_valid", mem_req_valid, 0);
    chk("post_rst_no_ifu_resp", ifu_resp_valid, 0);
    chk("post_rst_no_lsu_resp", lsu_resp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
